// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EXE/MEM register-use info in, pipeline controls,
// forwarding selects, FSM state and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       exe_rn;
    logic [4:0]       mem_rn;
    logic             exe_wreg;
    logic             mem_wreg;
    logic             exe_m2reg;
    logic             mem_m2reg;
    logic [1:0]       pcsource;
    logic             ext_stall;

    logic             wpcir;
    logic             id_bubble;
    logic             if_flush;
    logic             pipe_hold;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    // Pipeline side: supplies register-use info, consumes the controls.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output exe_rn, mem_rn, exe_wreg, mem_wreg, exe_m2reg, mem_m2reg,
        output pcsource, ext_stall,
        input  wpcir, id_bubble, if_flush, pipe_hold, fwda, fwdb,
        input  cycle_cnt, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  exe_rn, mem_rn, exe_wreg, mem_wreg, exe_m2reg, mem_m2reg,
        input  pcsource, ext_stall,
        output wpcir, id_bubble, if_flush, pipe_hold, fwda, fwdb,
        output cycle_cnt, stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: forwarding, load-use stall, branch flush, freeze.
// Controls are zero-latency combinational; state and saturating counters update on the edge.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic Clock,
    input  logic Resetn,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FREEZE   = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic             lu_hazard;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rt;
    logic             wpcir;
    logic             id_bubble;
    logic             if_flush;
    logic             pipe_hold;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;

    // A load in EXE cannot forward yet; only ALU results are taken from EXE.
    function automatic logic [1:0] fwd_sel(
        input logic       use_r,
        input logic [4:0] r,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r) begin
            if (e_wreg && !e_m2reg && e_rn != 5'd0 && e_rn == r)
                sel = 2'b01;
            else if (m_wreg && m_rn != 5'd0 && m_rn == r)
                sel = m_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_rs = fwd_sel(hz.id_use_rs, hz.id_rs, hz.exe_rn, hz.exe_wreg, hz.exe_m2reg,
                         hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
        fwd_rt = fwd_sel(hz.id_use_rt, hz.id_rt, hz.exe_rn, hz.exe_wreg, hz.exe_m2reg,
                         hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
        lu_hazard = hz.exe_wreg && hz.exe_m2reg && hz.exe_rn != 5'd0 &&
                    ((hz.id_use_rs && hz.exe_rn == hz.id_rs) ||
                     (hz.id_use_rt && hz.exe_rn == hz.id_rt));
    end

    // Freeze beats load-use, which beats flush: a stalled branch re-resolves next cycle.
    always_comb begin
        wpcir     = 1'b1;
        id_bubble = 1'b0;
        if_flush  = 1'b0;
        pipe_hold = 1'b0;
        fwda      = fwd_rs;
        fwdb      = fwd_rt;
        if (Resetn) begin
            fwda = 2'b00;
            fwdb = 2'b00;
        end else if (hz.ext_stall) begin
            pipe_hold = 1'b1;
            wpcir     = 1'b0;
        end else if (lu_hazard) begin
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end else begin
            if_flush  = (hz.pcsource != 2'b00);
        end
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state     <= RUN;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.ext_stall)
                state <= FREEZE;
            else if (lu_hazard)
                state <= LU_STALL;
            else
                state <= RUN;

            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (!wpcir && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (if_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.wpcir     = wpcir;
    assign hz.id_bubble = id_bubble;
    assign hz.if_flush  = if_flush;
    assign hz.pipe_hold = pipe_hold;
    assign hz.fwda      = fwda;
    assign hz.fwdb      = fwdb;
    assign hz.cycle_cnt = cycle_cnt;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
    assign hz.state     = state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipe_hazard_ctrl_if #(.CNT_W(3))  hs ();

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .Clock  (clk),
        .Resetn (rst),
        .hz     (hz.slave)
    );

    pipe_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .Clock  (clk),
        .Resetn (rst_s),
        .hz     (hs.slave)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] ern, mrn;
        logic       ew, mw, el, ml;
        logic [1:0] pcs;
        logic       ext;
        logic       wpc, bub, fl, hold;
        logic [1:0] fa, fb;
    } vec_t;

    function automatic vec_t mk(input int rs, rt, urs, urt, ern, mrn, ew, mw, el, ml,
                                input int pcs, ext, wpc, bub, fl, hold, fa, fb);
        vec_t v;
        v.rs = 5'(rs);   v.rt = 5'(rt);   v.urs = 1'(urs); v.urt = 1'(urt);
        v.ern = 5'(ern); v.mrn = 5'(mrn); v.ew = 1'(ew);   v.mw = 1'(mw);
        v.el = 1'(el);   v.ml = 1'(ml);   v.pcs = 2'(pcs); v.ext = 1'(ext);
        v.wpc = 1'(wpc); v.bub = 1'(bub); v.fl = 1'(fl);   v.hold = 1'(hold);
        v.fa = 2'(fa);   v.fb = 2'(fb);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        hz.id_rs = v.rs;      hz.id_rt = v.rt;
        hz.id_use_rs = v.urs; hz.id_use_rt = v.urt;
        hz.exe_rn = v.ern;    hz.mem_rn = v.mrn;
        hz.exe_wreg = v.ew;   hz.mem_wreg = v.mw;
        hz.exe_m2reg = v.el;  hz.mem_m2reg = v.ml;
        hz.pcsource = v.pcs;  hz.ext_stall = v.ext;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input vec_t v);
        chk({tag, "_wpcir"},  16'(hz.wpcir),     16'(v.wpc));
        chk({tag, "_bubble"}, 16'(hz.id_bubble), 16'(v.bub));
        chk({tag, "_flush"},  16'(hz.if_flush),  16'(v.fl));
        chk({tag, "_hold"},   16'(hz.pipe_hold), 16'(v.hold));
        chk({tag, "_fwda"},   16'(hz.fwda),      16'(v.fa));
        chk({tag, "_fwdb"},   16'(hz.fwdb),      16'(v.fb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[16];
    vec_t idle, lu_exe, lu_mem, lu_br, lu_mem_br, frz_lu;

    initial begin
        //          rs rt urs urt ern mrn ew mw el ml pcs ext | wpc bub fl hold fa fb
        vt[0]  = mk(3, 0, 1, 0,  3, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
        vt[1]  = mk(3, 0, 1, 0,  0, 3, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 2, 0);
        vt[2]  = mk(3, 0, 1, 0,  3, 3, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
        vt[3]  = mk(0, 7, 0, 1,  0, 7, 0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 3);
        vt[4]  = mk(3, 0, 0, 0,  3, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        vt[5]  = mk(0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        vt[7]  = mk(0, 5, 0, 1,  5, 0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        vt[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0);
        vt[9]  = mk(0, 5, 0, 1,  5, 0, 1, 0, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 0);
        vt[11] = mk(5, 0, 1, 0,  5, 0, 1, 0, 1, 0, 0, 1,   0, 0, 0, 1, 0, 0);
        vt[12] = mk(4, 4, 1, 1,  4, 4, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        vt[13] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,   1, 0, 1, 0, 0, 0);
        vt[14] = mk(9, 6, 1, 1,  6, 9, 1, 1, 0, 0, 2, 0,   1, 0, 1, 0, 2, 1);
        vt[15] = mk(5, 0, 1, 0,  5, 5, 1, 1, 1, 0, 0, 0,   0, 1, 0, 0, 2, 0);

        idle      = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        lu_exe    = mk(0, 5, 0, 1,  5, 0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        lu_mem    = mk(0, 5, 0, 1,  0, 5, 0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 3);
        lu_br     = mk(0, 5, 0, 1,  5, 0, 1, 0, 1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        lu_mem_br = mk(0, 5, 0, 1,  0, 5, 0, 1, 0, 1, 1, 0,   1, 0, 1, 0, 0, 3);
        frz_lu    = mk(0, 5, 0, 1,  5, 0, 1, 0, 1, 0, 0, 1,   0, 0, 0, 1, 0, 0);

        // Saturation instance: freeze forever so stall_cnt also saturates.
        hs.id_rs = '0; hs.id_rt = '0; hs.id_use_rs = 1'b0; hs.id_use_rt = 1'b0;
        hs.exe_rn = '0; hs.mem_rn = '0; hs.exe_wreg = 1'b0; hs.mem_wreg = 1'b0;
        hs.exe_m2reg = 1'b0; hs.mem_m2reg = 1'b0; hs.pcsource = 2'b00; hs.ext_stall = 1'b1;

        // Reset held 2 cycles with a hazard-looking input set and ext_stall asserted.
        rst = 1'b1;
        rst_s = 1'b1;
        apply(frz_lu);
        hz.pcsource = 2'b01;
        tick();
        tick();
        chk_ctl("reset", idle);
        chk("reset_state", 16'(hz.state),     16'd0);
        chk("reset_cycle", hz.cycle_cnt,      16'd0);
        chk("reset_stall", hz.stall_cnt,      16'd0);
        chk("reset_flush", hz.flush_cnt,      16'd0);
        rst_s = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vt[i]);
            #2;
            chk_ctl($sformatf("v%0d", i), vt[i]);
        end

        // Load-use: one stall cycle, then the load forwards from MEM.
        rst = 1'b1; apply(idle); tick(); rst = 1'b0;
        apply(lu_exe); #1;
        chk_ctl("lu_c0", lu_exe);
        tick();
        apply(lu_mem); #1;
        chk_ctl("lu_c1", lu_mem);
        chk("lu_state", 16'(hz.state), 16'd1);
        chk("lu_stall_cnt", hz.stall_cnt, 16'd1);
        chk("lu_cycle_cnt", hz.cycle_cnt, 16'd1);

        // Branch during load-use: flush deferred by one cycle.
        rst = 1'b1; apply(idle); tick(); rst = 1'b0;
        apply(lu_br); #1;
        chk_ctl("br_c0", lu_br);
        tick();
        apply(lu_mem_br); #1;
        chk_ctl("br_c1", lu_mem_br);
        tick();
        apply(idle); #1;
        chk("br_flush_cnt", hz.flush_cnt, 16'd1);
        chk("br_stall_cnt", hz.stall_cnt, 16'd1);
        chk("br_state", 16'(hz.state), 16'd0);

        // Freeze 3 cycles over a load-use hazard, then the stall is still taken.
        rst = 1'b1; apply(idle); tick(); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply(frz_lu); #1;
            chk_ctl($sformatf("frz_c%0d", c), frz_lu);
            tick();
            chk($sformatf("frz_state%0d", c), 16'(hz.state), 16'd2);
        end
        apply(lu_exe); #1;
        chk_ctl("frz_lu", lu_exe);
        tick();
        chk("frz_lu_state", 16'(hz.state), 16'd1);
        apply(lu_mem); #1;
        chk_ctl("frz_after", lu_mem);
        tick();
        chk("frz_stall_cnt", hz.stall_cnt, 16'd4);
        chk("frz_cycle_cnt", hz.cycle_cnt, 16'd5);
        chk("frz_end_state", 16'(hz.state), 16'd0);

        // Reset mid-freeze returns to RUN with no bubble carried over.
        apply(frz_lu); tick();
        chk("mid_state", 16'(hz.state), 16'd2);
        rst = 1'b1; #1;
        chk_ctl("mid_rst", idle);
        tick();
        chk("mid_rst_state", 16'(hz.state), 16'd0);
        chk("mid_rst_cycle", hz.cycle_cnt, 16'd0);
        rst = 1'b0;
        apply(idle); #1;
        chk_ctl("mid_post", idle);
        tick();
        chk("mid_post_stall", hz.stall_cnt, 16'd0);
        chk("mid_post_cycle", hz.cycle_cnt, 16'd1);

        // Narrow counters have seen far more than 7 cycles by now.
        chk("sat_cycle", 16'(hs.cycle_cnt), 16'd7);
        chk("sat_stall", 16'(hs.stall_cnt), 16'd7);
        chk("sat_flush", 16'(hs.flush_cnt), 16'd0);
        chk("sat_state", 16'(hs.state),     16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller for the five-stage pipeline. It takes register-use information from ID and destination/write-enable information from EXE and MEM. From these it produces operand-forwarding selects, load-use stalls, taken-branch/jump flushes of IF/ID, and a global freeze for external stall requests. It also keeps saturating performance counters. It sits beside ID_STAGE and drives the write-enables and bubble/flush controls of the PC, IF/ID and ID/EXE registers.

## Interface
- CNT_W, 16, width of each performance counter

- Clock  in  1  system clock, rising edge
- Resetn  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- exe_rn, mem_rn  in  5 each  destination register in EXE / MEM
- exe_wreg, mem_wreg  in  1 each  register-write enable in EXE / MEM
- exe_m2reg, mem_m2reg  in  1 each  instruction in EXE / MEM is a load
- pcsource  in  2  ID next-PC select; 00 = PC+4, any other value = taken branch/jump
- ext_stall  in  1  external freeze request (e.g. multi-cycle memory)
- wpcir  out  1  PC and IF/ID write enable (0 = hold)
- id_bubble  out  1  force ID/EXE control bits (wreg, wmem, m2reg) to 0
- if_flush  out  1  load a NOP into IF/ID on the next edge
- pipe_hold  out  1  hold ID/EXE, EXE/MEM and MEM/WB (ext freeze)
- fwda, fwdb  out  2 each  operand select for ra / rb: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters
- state  out  2  FSM state: 00 RUN, 01 LU_STALL, 10 FREEZE

## Operation
- Register $0 never hazards. Any comparison with rn == 0 is false.
- Forwarding for rs (rt identical, producing fwdb) applies only when id_use_rs = 1:
  - If exe_wreg && !exe_m2reg && exe_rn == id_rs, then 01.
  - Else if mem_wreg && mem_rn == id_rs, then 11 if mem_m2reg, otherwise 10.
  - Else 00.
  - EXE has priority over MEM.
- lu_hazard = exe_wreg && exe_m2reg && exe_rn != 0 && ((id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt)).
- Outputs are combinational from inputs and state. Priority is ext_stall > lu_hazard > flush:
  - ext_stall = 1: pipe_hold = 1, wpcir = 0, id_bubble = 0, if_flush = 0.
  - Else lu_hazard = 1: wpcir = 0, id_bubble = 1, if_flush = 0. pcsource is ignored because the branch operand is not ready.
  - Else: wpcir = 1, id_bubble = 0, if_flush = (pcsource != 00).
- FSM, registered, next-state:
  - ext_stall goes to FREEZE.
  - Else lu_hazard goes to LU_STALL.
  - Else goes to RUN.
  - Leaving FREEZE re-evaluates the hazard on the same held inputs. No hazard is lost.
- In LU_STALL the load has advanced to MEM, so forwarding selects 11. lu_hazard cannot be raised again by the same load. A new load in EXE can raise it, and the FSM stays in LU_STALL.
- Counters saturate at all-ones:
  - cycle_cnt increments every non-reset cycle.
  - stall_cnt increments each cycle wpcir = 0, which covers both load-use stalls and freezes.
  - flush_cnt increments each cycle if_flush = 1.

## Timing
- Reset, synchronous, takes effect at the first rising edge with Resetn = 1:
  - state = RUN and all counters = 0.
  - While Resetn = 1: wpcir = 1, id_bubble = 0, if_flush = 0, pipe_hold = 0, fwda = fwdb = 00.
- Reset mid-stall or mid-freeze returns to RUN at that edge, with no carried-over bubble.
- A load-use stall costs exactly 1 cycle per dependent load-use pair. A taken branch/jump costs 1 flushed slot.
- Outputs are valid in the same cycle as the inputs, with zero latency. State and counters update on the rising edge.
- ext_stall held for N cycles freezes the pipeline for exactly N cycles. stall_cnt grows by N.

## Test plan
- Reset: Resetn = 1 for 2 cycles with ext_stall = 1 -> all outputs at their defaults, counters 0, state = RUN.
- ALU chain, add $3 in EXE then ID reads $3 as rs -> fwda = 01. With the same producer in MEM instead -> fwda = 10. With producers in both -> 01.
- Load-use: lw $5 in EXE, ID reads rt = $5 -> wpcir = 0, id_bubble = 1 for 1 cycle. Next cycle: state = LU_STALL, load in MEM, fwdb = 11, wpcir = 1. stall_cnt = 1.
- $0 destination: exe_rn = 0, exe_wreg = 1, exe_m2reg = 1, id_rs = 0 -> no stall, fwda = 00.
- Branch: pcsource = 01, no hazard -> if_flush = 1. Same cycle with lu_hazard = 1 -> if_flush = 0, stall, then flush on the following cycle. flush_cnt = 1.
- Freeze: ext_stall = 1 for 3 cycles during a load-use hazard -> pipe_hold = 1 for 3 cycles. Then the load-use stall is taken for 1 cycle. stall_cnt = 4.
